// File: rtl/jt51_logsin_pkg.sv
// Shared widths, ROM word field offsets and the per-stage payload
// for the log-sine operator stage.
package jt51_logsin_pkg;
   localparam int unsigned PW       = 10;
   localparam int unsigned LW       = 12;
   localparam int unsigned ROMW     = 46;
   localparam int unsigned AW       = 5;
   localparam int unsigned SELW     = 3;
   localparam int unsigned BASE_MSB = 45;
   localparam int unsigned BASE_LSB = 36;
   localparam int unsigned DELTA_W  = 4;
   localparam int unsigned NDELTA   = 7;
   localparam int unsigned OFFW     = 7;

   typedef struct packed {
      logic [SELW-1:0] sel;
      logic            sign;
      logic            valid;
   } stage_t;
endpackage

// File: rtl/jt51_logsin_acc.sv
// Expands a compressed sine ROM word: base minus the first sel delta
// fields, clamped at zero.
module jt51_logsin_acc
   import jt51_logsin_pkg::*;
(
   input  logic [ROMW-1:0] rom_ph,
   input  logic [SELW-1:0] sel,
   output logic [LW-1:0]   logsin_c
);
   logic [OFFW-1:0] off;
   logic [LW-1:0]   base;
   logic            rsvd_unused;

   // Reserved byte between the delta fields and the base is not used.
   assign rsvd_unused = ^rom_ph[BASE_LSB-1:NDELTA*DELTA_W];

   always_comb begin
      off  = '0;
      base = {rom_ph[BASE_MSB:BASE_LSB], 2'b00};
      for (int k = 0; k < NDELTA; k++) begin
         if (SELW'(k) < sel) off = off + OFFW'(rom_ph[k*DELTA_W +: DELTA_W]);
      end
      logsin_c = (base < LW'(off)) ? '0 : base - LW'(off);
   end
endmodule

// File: rtl/jt51_logsin.sv
// Three-stage log-sine lookup: fold phase to a quarter wave and address
// the ROM, wait one stage for the ROM word, then expand it.
module jt51_logsin
   import jt51_logsin_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cen,
   input  logic [PW-1:0]   phase_in,
   input  logic            valid_in,
   output logic [AW-1:0]   rom_addr,
   input  logic [ROMW-1:0] rom_ph,
   output logic [LW-1:0]   logsin,
   output logic            sign_out,
   output logic            valid_out
);
   logic [7:0]    aux_c;
   logic [LW-1:0] logsin_c;

   logic [AW-1:0] rom_addr_q, rom_addr_d;
   stage_t        a_q, a_d;
   stage_t        b_q, b_d;
   logic [LW-1:0] logsin_q, logsin_d;
   logic          sign_q, sign_d;
   logic          valid_q, valid_d;

   assign aux_c = phase_in[8] ? ~phase_in[7:0] : phase_in[7:0];

   jt51_logsin_acc u_acc (
      .rom_ph   (rom_ph),
      .sel      (b_q.sel),
      .logsin_c (logsin_c)
   );

   always_comb begin
      rom_addr_d = rom_addr_q;
      a_d        = a_q;
      b_d        = b_q;
      logsin_d   = logsin_q;
      sign_d     = sign_q;
      valid_d    = valid_q;
      if (cen) begin
         rom_addr_d = aux_c[7:3];
         a_d        = '{sel: aux_c[2:0], sign: phase_in[9], valid: valid_in};
         // Stage B only delays, giving the ROM a full stage to settle.
         b_d        = a_q;
         logsin_d   = logsin_c;
         sign_d     = b_q.sign;
         valid_d    = b_q.valid;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rom_addr_q <= '0;
         a_q        <= '0;
         b_q        <= '0;
         logsin_q   <= '0;
         sign_q     <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         rom_addr_q <= rom_addr_d;
         a_q        <= a_d;
         b_q        <= b_d;
         logsin_q   <= logsin_d;
         sign_q     <= sign_d;
         valid_q    <= valid_d;
      end
   end

   assign rom_addr  = rom_addr_q;
   assign logsin    = logsin_q;
   assign sign_out  = sign_q;
   assign valid_out = valid_q;
endmodule
